// File: rtl/control_heroe_pkg.sv
// Shared game constants for the hero controller: game-FSM state codes, obstacle codes,
// hero glyphs and W_or_L result codes.
package control_heroe_pkg;

    localparam logic [2:0] OFF    = 3'd0;
    localparam logic [2:0] INICIO = 3'd1;
    localparam logic [2:0] WLCM   = 3'd2;
    localparam logic [2:0] GAME   = 3'd3;
    localparam logic [2:0] WL     = 3'd4;
    localparam logic [2:0] PA     = 3'd5;

    localparam logic [4:0] TIPO_BONO   = 5'd16;
    localparam logic [1:0] SALTO_TICKS = 2'd2;

    localparam logic [6:0] SEG_CORRE    = 7'b0011101;
    localparam logic [6:0] SEG_SALTO    = 7'b1100011;
    localparam logic [6:0] SEG_AGACHADO = 7'b0001000;

    localparam logic [1:0] WL_JUGANDO = 2'b00;
    localparam logic [1:0] WL_PIERDE  = 2'b01;
    localparam logic [1:0] WL_GANA    = 2'b10;

    typedef enum logic [1:0] {
        CORRE    = 2'd0,
        SALTO    = 2'd1,
        AGACHADO = 2'd2
    } estado_t;

    function automatic logic [6:0] glifo(input estado_t e);
        case (e)
            SALTO:    glifo = SEG_SALTO;
            AGACHADO: glifo = SEG_AGACHADO;
            default:  glifo = SEG_CORRE;
        endcase
    endfunction

endpackage

// File: rtl/control_heroe_detector_flanco.sv
// Rising-edge detector: flanco is high for the single clk in which d is 1 and was 0 before.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic flanco
);

    logic d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign flanco = d & ~d_q;

endmodule

// File: rtl/control_heroe.sv
// Hero controller: run/jump/duck FSM, shadow obstacle pipeline aligned with the display,
// collision / bonus / win evaluation once per obstacle step.
//
//  state    | meaning
//  ---------+---------------------------------------------------
//  CORRE    | hero running, hit by any obstacle
//  SALTO    | hero in the air for SALTO_TICKS steps, clears low obstacles
//  AGACHADO | hero ducking while btn_agacha held, clears high obstacles
module control_heroe
    import control_heroe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  presente,
    input  logic        clk_obstaculos,
    input  logic [4:0]  tipo_obs,
    input  logic [20:0] display_obs,
    input  logic [1:0]  mundo,
    input  logic        btn_salto,
    input  logic        btn_agacha,
    output logic [1:0]  W_or_L,
    output logic        bono_tomado,
    output logic [6:0]  heroe_seg,
    output logic [7:0]  esquivados
);

    logic       tick;
    logic       salto_flanco;
    estado_t    estado, estado_sig;
    logic [1:0] cnt_salto, cnt_salto_sig;
    logic [4:0] sh2, sh1, sh0;
    logic [4:0] sh2_nuevo, sh0_nuevo;
    logic       en_juego, activo, tick_act;
    logic       choque, esquiva, gana, bono;
    logic       unused_display;

    assign unused_display = ^display_obs[13:0];

    detector_flanco u_flanco_obs (
        .clk    (clk),
        .rst    (rst),
        .d      (clk_obstaculos),
        .flanco (tick)
    );

    detector_flanco u_flanco_salto (
        .clk    (clk),
        .rst    (rst),
        .d      (btn_salto),
        .flanco (salto_flanco)
    );

    assign en_juego = (presente == GAME) || (presente == WL);
    assign activo   = (presente == GAME) && (W_or_L == WL_JUGANDO);
    assign tick_act = tick && activo;
    assign gana     = activo && (mundo == 2'd3);

    // A blank entry digit still carries the bonus, which marks the world end.
    always_comb begin
        sh2_nuevo = 5'd0;
        if (display_obs[20:14] != 7'd0) sh2_nuevo = tipo_obs;
        else if (tipo_obs == TIPO_BONO) sh2_nuevo = TIPO_BONO;
    end

    assign sh0_nuevo = sh1;

    always_comb begin
        choque  = 1'b0;
        esquiva = 1'b0;
        bono    = 1'b0;
        if (tick_act && sh0_nuevo != 5'd0) begin
            if (sh0_nuevo == TIPO_BONO) begin
                bono = 1'b1;
            end else if (sh0_nuevo[0]) begin
                choque  = (estado != SALTO);
                esquiva = (estado == SALTO);
            end else begin
                choque  = (estado != AGACHADO);
                esquiva = (estado == AGACHADO);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado    <= CORRE;
            cnt_salto <= 2'd0;
        end else begin
            estado    <= estado_sig;
            cnt_salto <= cnt_salto_sig;
        end
    end

    // A colliding step freezes the pose, so the jump may not end on that step.
    always_comb begin
        estado_sig    = estado;
        cnt_salto_sig = cnt_salto;
        if (!en_juego) begin
            estado_sig    = CORRE;
            cnt_salto_sig = 2'd0;
        end else if (activo && !choque) begin
            case (estado)
                CORRE: begin
                    if (salto_flanco) begin
                        estado_sig    = SALTO;
                        cnt_salto_sig = SALTO_TICKS;
                    end else if (btn_agacha) begin
                        estado_sig = AGACHADO;
                    end
                end
                AGACHADO: begin
                    if (!btn_agacha) estado_sig = CORRE;
                end
                SALTO: begin
                    if (tick) begin
                        cnt_salto_sig = cnt_salto - 2'd1;
                        if (cnt_salto_sig == 2'd0) estado_sig = CORRE;
                    end
                end
                default: estado_sig = CORRE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh2         <= 5'd0;
            sh1         <= 5'd0;
            sh0         <= 5'd0;
            esquivados  <= 8'd0;
            W_or_L      <= WL_JUGANDO;
            bono_tomado <= 1'b0;
        end else if (!en_juego) begin
            sh2         <= 5'd0;
            sh1         <= 5'd0;
            sh0         <= 5'd0;
            esquivados  <= 8'd0;
            W_or_L      <= WL_JUGANDO;
            bono_tomado <= 1'b0;
        end else begin
            bono_tomado <= bono;
            if (tick_act) begin
                sh2 <= sh2_nuevo;
                sh1 <= sh2;
                sh0 <= sh0_nuevo;
            end
            if (esquiva && esquivados != 8'hFF) esquivados <= esquivados + 8'd1;
            if (gana)        W_or_L <= WL_GANA;
            else if (choque) W_or_L <= WL_PIERDE;
        end
    end

    assign heroe_seg = glifo(estado);

endmodule

// File: tb/tb_control_heroe.sv
// Self-checking bench for control_heroe: table of obstacle steps with expected outputs
// routed through a scoreboard queue, plus hand sequences for loss/exit, win and reset.
module tb_control_heroe;
    import control_heroe_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  presente;
    logic        clk_obstaculos;
    logic [4:0]  tipo_obs;
    logic [20:0] display_obs;
    logic [1:0]  mundo;
    logic        btn_salto;
    logic        btn_agacha;
    logic [1:0]  W_or_L;
    logic        bono_tomado;
    logic [6:0]  heroe_seg;
    logic [7:0]  esquivados;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] tipo;
        logic       top;
        logic       salto;
        logic       agacha;
        logic [1:0] e_wl;
        logic [7:0] e_esq;
        logic       e_bono;
        logic [6:0] e_seg;
    } vec_t;

    typedef struct {
        logic [1:0] wl;
        logic [7:0] esq;
        logic       bono;
        logic [6:0] seg;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    control_heroe dut (
        .clk            (clk),
        .rst            (rst),
        .presente       (presente),
        .clk_obstaculos (clk_obstaculos),
        .tipo_obs       (tipo_obs),
        .display_obs    (display_obs),
        .mundo          (mundo),
        .btn_salto      (btn_salto),
        .btn_agacha     (btn_agacha),
        .W_or_L         (W_or_L),
        .bono_tomado    (bono_tomado),
        .heroe_seg      (heroe_seg),
        .esquivados     (esquivados)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, " W_or_L"}, {6'd0, W_or_L}, {6'd0, e.wl});
        check({tag, " esquivados"}, esquivados, e.esq);
        check({tag, " bono_tomado"}, {7'd0, bono_tomado}, {7'd0, e.bono});
        check({tag, " heroe_seg"}, {1'b0, heroe_seg}, {1'b0, e.seg});
    endtask

    // One obstacle step: buttons are applied a clk before the step, then one tick.
    task automatic do_step(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        btn_agacha  = v.agacha;
        btn_salto   = v.salto;
        tipo_obs    = v.tipo;
        display_obs = {(v.top ? 7'h3F : 7'h00), 14'h0};
        @(negedge clk);
        btn_salto      = 1'b0;
        clk_obstaculos = 1'b1;
        e.wl = v.e_wl; e.esq = v.e_esq; e.bono = v.e_bono; e.seg = v.e_seg;
        sb.push_back(e);
        @(negedge clk);
        clk_obstaculos = 1'b0;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check_outputs(tag, e);
        end
        @(negedge clk);
        check({tag, " bono one clk"}, {7'd0, bono_tomado}, 8'd0);
    endtask

    function automatic vec_t mk(input logic [4:0] tipo, input logic top, input logic salto,
                                input logic agacha, input logic [1:0] wl, input logic [7:0] esq,
                                input logic bono, input logic [6:0] seg);
        vec_t v;
        v.tipo = tipo; v.top = top; v.salto = salto; v.agacha = agacha;
        v.e_wl = wl; v.e_esq = esq; v.e_bono = bono; v.e_seg = seg;
        return v;
    endfunction

    initial begin
        exp_t e;
        // Game A: jump over low, duck under high, bonus, then a low obstacle hits a runner.
        vecs[0]  = mk(5'd3,  1, 0, 0, 2'b00, 8'd0, 0, SEG_CORRE);
        vecs[1]  = mk(5'd0,  0, 1, 0, 2'b00, 8'd0, 0, SEG_SALTO);
        vecs[2]  = mk(5'd0,  0, 0, 0, 2'b00, 8'd1, 0, SEG_CORRE);
        vecs[3]  = mk(5'd4,  1, 0, 1, 2'b00, 8'd1, 0, SEG_AGACHADO);
        vecs[4]  = mk(5'd0,  0, 0, 1, 2'b00, 8'd1, 0, SEG_AGACHADO);
        vecs[5]  = mk(5'd0,  0, 0, 1, 2'b00, 8'd2, 0, SEG_AGACHADO);
        vecs[6]  = mk(5'd16, 0, 0, 0, 2'b00, 8'd2, 0, SEG_CORRE);
        vecs[7]  = mk(5'd0,  0, 0, 0, 2'b00, 8'd2, 0, SEG_CORRE);
        vecs[8]  = mk(5'd0,  0, 0, 0, 2'b00, 8'd2, 1, SEG_CORRE);
        vecs[9]  = mk(5'd7,  1, 0, 0, 2'b00, 8'd2, 0, SEG_CORRE);
        vecs[10] = mk(5'd0,  0, 0, 0, 2'b00, 8'd2, 0, SEG_CORRE);
        vecs[11] = mk(5'd0,  0, 0, 0, 2'b01, 8'd2, 0, SEG_CORRE);
        vecs[12] = mk(5'd9,  1, 1, 0, 2'b01, 8'd2, 0, SEG_CORRE);
        // Game B: jumping into a high obstacle loses and freezes the SALTO pose.
        vecs[13] = mk(5'd4,  1, 0, 0, 2'b00, 8'd0, 0, SEG_CORRE);
        vecs[14] = mk(5'd0,  0, 1, 0, 2'b00, 8'd0, 0, SEG_SALTO);
        vecs[15] = mk(5'd0,  0, 0, 0, 2'b01, 8'd0, 0, SEG_SALTO);

        rst = 1'b1; presente = OFF; clk_obstaculos = 1'b0; tipo_obs = 5'd0;
        display_obs = 21'd0; mundo = 2'd0; btn_salto = 1'b0; btn_agacha = 1'b0;
        repeat (3) @(negedge clk);
        e.wl = 2'b00; e.esq = 8'd0; e.bono = 1'b0; e.seg = SEG_CORRE;
        check_outputs("reset", e);
        rst = 1'b0;
        @(negedge clk);
        presente = GAME;
        @(negedge clk);

        for (int i = 0; i < 13; i++) do_step($sformatf("A%0d", i), vecs[i]);

        // Loss holds through WL, clears on leaving.
        presente = WL;
        repeat (2) @(negedge clk);
        check("WL hold W_or_L", {6'd0, W_or_L}, 8'd1);
        check("WL hold esquivados", esquivados, 8'd2);
        presente = WLCM;
        @(negedge clk);
        e.wl = 2'b00; e.esq = 8'd0; e.bono = 1'b0; e.seg = SEG_CORRE;
        check_outputs("exit", e);
        presente = GAME;
        @(negedge clk);

        for (int i = 13; i < 16; i++) do_step($sformatf("B%0d", i), vecs[i]);

        // Win on mundo==3.
        presente = WLCM;
        @(negedge clk);
        check("clear seg", {1'b0, heroe_seg}, {1'b0, SEG_CORRE});
        presente = GAME;
        mundo = 2'd3;
        @(negedge clk);
        check("win W_or_L", {6'd0, W_or_L}, 8'd2);
        mundo = 2'd0;
        presente = WLCM;
        @(negedge clk);
        check("after win clear", {6'd0, W_or_L}, 8'd0);
        presente = GAME;
        @(negedge clk);

        // Async reset mid-jump with a high obstacle in the pipeline.
        do_step("R0", mk(5'd3, 1, 0, 0, 2'b00, 8'd0, 0, SEG_CORRE));
        do_step("R1", mk(5'd0, 0, 1, 0, 2'b00, 8'd0, 0, SEG_SALTO));
        do_step("R2", mk(5'd4, 1, 0, 0, 2'b00, 8'd1, 0, SEG_CORRE));
        do_step("R3", mk(5'd0, 0, 1, 0, 2'b00, 8'd1, 0, SEG_SALTO));
        #2;
        rst = 1'b1;
        #1;
        e.wl = 2'b00; e.esq = 8'd0; e.bono = 1'b0; e.seg = SEG_CORRE;
        check_outputs("async rst", e);
        @(negedge clk);
        rst = 1'b0;
        do_step("P0", mk(5'd0, 0, 0, 0, 2'b00, 8'd0, 0, SEG_CORRE));
        do_step("P1", mk(5'd0, 0, 0, 0, 2'b00, 8'd0, 0, SEG_CORRE));
        do_step("P2", mk(5'd0, 0, 0, 0, 2'b00, 8'd0, 0, SEG_CORRE));

        check("scoreboard drained", sb.size()[7:0], 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
